// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for seq_restoring_divider.
// Signed operation port appears only when SIGNED_DIV_EN is defined.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
   logic             signed_mode;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

`ifdef SIGNED_DIV_EN
   modport master (
      output start, dividend, divisor, signed_mode,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor, signed_mode,
      output busy, done, quotient, remainder, div_by_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per enabled clock.
// Optional macro SIGNED_DIV_EN adds two's complement mode via signed_mode.
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic             dv_zero;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dq_q;
   logic [WIDTH-1:0] dvs_q;
   logic             dz_q;

   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rmd_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;

   logic [WIDTH:0]   shifted;
   logic             fit;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] dd_ld;
   logic [WIDTH-1:0] dv_ld;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

`ifdef SIGNED_DIV_EN
   logic             neg_dd;
   logic             neg_dv;
   logic             negq_q;
   logic             negr_q;
`endif

   assign dv_zero = (bus.divisor == '0);

   // Next-state: start is only honoured in IDLE; zero divisor skips RUN.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = dv_zero ? FIN : RUN;
            end
         end
         RUN: begin
            if (cnt_q == CW'(1)) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register, frozen while ena is low.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else if (ena) state_q <= state_d;
   end

   // One restoring step: shift in next dividend bit, subtract if it fits.
   always_comb begin
      shifted = {rem_q, dq_q[WIDTH-1]};
      fit     = (shifted >= {1'b0, dvs_q});
      diff    = shifted[WIDTH-1:0] - dvs_q;
   end

   // Operand conditioning at load: magnitudes in signed mode.
   always_comb begin
      dd_ld = bus.dividend;
      dv_ld = bus.divisor;
`ifdef SIGNED_DIV_EN
      neg_dd = bus.signed_mode & bus.dividend[WIDTH-1];
      neg_dv = bus.signed_mode & bus.divisor[WIDTH-1];
      if (neg_dd) dd_ld = -bus.dividend;
      if (neg_dv) dv_ld = -bus.divisor;
`endif
   end

   // Final result: sign fix-up, or the fixed divide-by-zero answer.
   always_comb begin
      q_fin = dq_q;
      r_fin = rem_q;
`ifdef SIGNED_DIV_EN
      if (negq_q) q_fin = -dq_q;
      if (negr_q) r_fin = -rem_q;
`endif
      if (dz_q) begin
         q_fin = '1;
         r_fin = dq_q;
      end
   end

   // Datapath, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         dq_q   <= '0;
         dvs_q  <= '0;
         dz_q   <= 1'b0;
         quo_q  <= '0;
         rmd_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
         negq_q <= 1'b0;
         negr_q <= 1'b0;
`endif
      end else if (ena) begin
         busy_q <= (state_q == RUN);
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  rem_q <= '0;
                  dvs_q <= dv_ld;
                  dq_q  <= dv_zero ? bus.dividend : dd_ld;
                  dz_q  <= dv_zero;
                  cnt_q <= dv_zero ? '0 : CW'(WIDTH);
                  dbz_q <= 1'b0;
`ifdef SIGNED_DIV_EN
                  negq_q <= neg_dd ^ neg_dv;
                  negr_q <= neg_dd;
`endif
               end
            end
            RUN: begin
               rem_q <= fit ? diff : shifted[WIDTH-1:0];
               dq_q  <= {dq_q[WIDTH-2:0], fit};
               cnt_q <= cnt_q - CW'(1);
            end
            FIN: begin
               quo_q  <= q_fin;
               rmd_q  <= r_fin;
               dbz_q  <= dz_q;
               done_q <= 1'b1;
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised and directed bench for seq_restoring_divider (WIDTH=8).
// Reference results come from plain integer division in the bench.
module tb_seq_restoring_divider;
   localparam int W = 8;

   logic clk;
   logic rst;
   logic ena;
   int   n_checks;
   int   n_fail;

   seq_restoring_divider_if #(.WIDTH(W)) bus ();

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: integer division, truncating toward zero in signed mode.
   function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                 input bit sm, output logic [W-1:0] q,
                                 output logic [W-1:0] r);
      int a;
      int b;
      if (dv == 0) begin
         q = '1;
         r = dd;
         return;
      end
      if (sm) begin
         a = int'($signed(dd));
         b = int'($signed(dv));
      end else begin
         a = int'(dd);
         b = int'(dv);
      end
      q = W'(a / b);
      r = W'(a % b);
   endfunction

   task automatic set_ops(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input bit sm);
      bus.dividend = dd;
      bus.divisor  = dv;
`ifdef SIGNED_DIV_EN
      bus.signed_mode = sm;
`else
      if (sm) bus.dividend = dd;
`endif
   endtask

   // Issue one start and wait (bounded) for done; lat = enabled edges after accept edge.
   task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input bit sm, input bit scramble,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat, output int nbusy,
                         output bit overlap);
      @(negedge clk);
      bus.start = 1'b1;
      set_ops(dd, dv, sm);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      nbusy = 0;
      overlap = 1'b0;
      while (!bus.done && lat < 100) begin
         if (bus.busy) nbusy++;
         if (scramble) begin
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (bus.busy && bus.done) overlap = 1'b1;
      q = bus.quotient;
      r = bus.remainder;
      dz = bus.div_by_zero;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b1;
      bus.start = 1'b0;
      set_ops('0, '0, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL reset_done got %b want 0", bus.done);
      end
      n_checks++;
      if (bus.quotient !== 8'h00) begin
         n_fail++; $display("FAIL reset_q got %h want 00", bus.quotient);
      end
      n_checks++;
      if (bus.remainder !== 8'h00) begin
         n_fail++; $display("FAIL reset_r got %h want 00", bus.remainder);
      end
      n_checks++;
      if (bus.div_by_zero !== 1'b0) begin
         n_fail++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] q, r;
      logic dz;
      int lat, nb;
      bit ov;
      run_op(8'd200, 8'd7, 1'b0, 1'b0, q, r, dz, lat, nb, ov);
      n_checks++;
      if (lat !== 9) begin
         n_fail++; $display("FAIL basic_latency got %0d want 9", lat);
      end
      n_checks++;
      if (nb !== 8) begin
         n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", nb);
      end
      n_checks++;
      if (ov !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy_done_overlap got 1 want 0");
      end
      n_checks++;
      if (q !== 8'h1C || r !== 8'h04 || dz !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result got q=%h r=%h dz=%b want q=1c r=04 dz=0", q, r, dz);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] tdd [2] = '{8'hFF, 8'h05};
      logic [W-1:0] tdv [2] = '{8'h01, 8'h09};
      logic [W-1:0] tq  [2] = '{8'hFF, 8'h00};
      logic [W-1:0] tr  [2] = '{8'h00, 8'h05};
      logic [W-1:0] q, r;
      logic dz;
      int lat, nb;
      bit ov;
      for (int i = 0; i < 2; i++) begin
         run_op(tdd[i], tdv[i], 1'b0, 1'b0, q, r, dz, lat, nb, ov);
         n_checks++;
         if (q !== tq[i] || r !== tr[i]) begin
            n_fail++;
            $display("FAIL directed_%0d got q=%h r=%h want q=%h r=%h", i, q, r, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      logic [W-1:0] q, r;
      logic dz;
      int lat, nb;
      bit ov;
      run_op(8'h2A, 8'h00, 1'b0, 1'b0, q, r, dz, lat, nb, ov);
      n_checks++;
      if (lat !== 1) begin
         n_fail++; $display("FAIL dbz_latency got %0d want 1", lat);
      end
      n_checks++;
      if (nb !== 0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL dbz_busy got %0d cycles want 0", nb);
      end
      n_checks++;
      if (q !== 8'hFF || r !== 8'h2A || dz !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_result got q=%h r=%h dz=%b want q=ff r=2a dz=1", q, r, dz);
      end
   endtask

   task automatic test_ena_ignored_start();
      int k, ndone;
      @(negedge clk);
      bus.start = 1'b1;
      set_ops(8'd100, 8'd3, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 100) begin
         if (k == 3) begin
            bus.start = 1'b1;
            set_ops(8'd50, 8'd5, 1'b0);
         end
         if (k == 4) bus.start = 1'b0;
         if (k == 5) ena = 1'b0;
         if (k == 7) ena = 1'b1;
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k !== 11) begin
         n_fail++; $display("FAIL ena_latency got %0d want 11", k);
      end
      n_checks++;
      if (bus.quotient !== 8'd33 || bus.remainder !== 8'd1) begin
         n_fail++;
         $display("FAIL ena_result got q=%0d r=%0d want q=33 r=1", bus.quotient, bus.remainder);
      end
      ena = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++; $display("FAIL done_hold_ena got %b want 1", bus.done);
      end
      ena = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL done_release_ena got %b want 0", bus.done);
      end
      ndone = 0;
      repeat (14) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      n_checks++;
      if (ndone !== 0) begin
         n_fail++; $display("FAIL ignored_start got %0d extra done want 0", ndone);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] q, r;
      logic dz;
      int lat, nb, ndone;
      bit ov;
      @(negedge clk);
      bus.start = 1'b1;
      set_ops(8'd200, 8'd7, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'h00 ||
          bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs got b=%b d=%b q=%h r=%h dz=%b want all 0",
                  bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      rst = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      n_checks++;
      if (ndone !== 0) begin
         n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone);
      end
      run_op(8'd9, 8'd2, 1'b0, 1'b0, q, r, dz, lat, nb, ov);
      n_checks++;
      if (q !== 8'd4 || r !== 8'd1 || lat !== 9) begin
         n_fail++;
         $display("FAIL abort_recover got q=%0d r=%0d lat=%0d want q=4 r=1 lat=9", q, r, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ad, av, bd, bv, eq, er;
      int k, first;
      ad = W'($urandom); av = W'($urandom_range(1, 255));
      bd = W'($urandom); bv = W'($urandom_range(1, 255));
      @(negedge clk);
      bus.start = 1'b1;
      set_ops(ad, av, 1'b0);
      @(negedge clk);
      k = 0;
      first = -1;
      while (k < 100) begin
         if (bus.done && first < 0) begin
            first = k;
            model(ad, av, 1'b0, eq, er);
            n_checks++;
            if (bus.quotient !== eq || bus.remainder !== er) begin
               n_fail++;
               $display("FAIL b2b_first got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, eq, er);
            end
            set_ops(bd, bv, 1'b0);
         end else if (bus.done) begin
            bus.start = 1'b0;
            break;
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      n_checks++;
      if (first !== 9 || k - first !== 10) begin
         n_fail++; $display("FAIL b2b_rate got first=%0d gap=%0d want 9 and 10", first, k - first);
      end
      model(bd, bv, 1'b0, eq, er);
      n_checks++;
      if (bus.quotient !== eq || bus.remainder !== er) begin
         n_fail++;
         $display("FAIL b2b_second got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, eq, er);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] dd, dv, q, r, eq, er;
      logic dz;
      int lat, nb, elat;
      bit ov, sm;
      for (int i = 0; i < 40; i++) begin
         dd = W'($urandom);
         dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef SIGNED_DIV_EN
         sm = 1'($urandom);
`else
         sm = 1'b0;
`endif
         model(dd, dv, sm, eq, er);
         elat = (dv == 0) ? 1 : 9;
         run_op(dd, dv, sm, 1'b1, q, r, dz, lat, nb, ov);
         n_checks++;
         if (q !== eq || r !== er || dz !== (dv == 0) || lat !== elat || ov) begin
            n_fail++;
            $display("FAIL random_%0d %h/%h sm=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h lat=%0d",
                     i, dd, dv, sm, q, r, dz, lat, eq, er, elat);
         end
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed();
      logic [W-1:0] tdd [3] = '{8'h9C, 8'h80, 8'h9C};
      logic [W-1:0] tdv [3] = '{8'h07, 8'hFF, 8'h00};
      logic [W-1:0] tq  [3] = '{8'hF2, 8'h80, 8'hFF};
      logic [W-1:0] tr  [3] = '{8'hFE, 8'h00, 8'h9C};
      logic [W-1:0] q, r;
      logic dz;
      int lat, nb;
      bit ov;
      for (int i = 0; i < 3; i++) begin
         run_op(tdd[i], tdv[i], 1'b1, 1'b0, q, r, dz, lat, nb, ov);
         n_checks++;
         if (q !== tq[i] || r !== tr[i]) begin
            n_fail++;
            $display("FAIL signed_%0d got q=%h r=%h want q=%h r=%h", i, q, r, tq[i], tr[i]);
         end
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      ena = 1'b1;
      bus.start = 1'b0;
      set_ops('0, '0, 1'b0);
      test_reset();
      test_basic();
      test_directed();
      test_div_by_zero();
      test_ena_ignored_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
